// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter/sequencer that shares one combinational ALU between two
// requesters: accept one op, drive the ALU for a cycle, then hold the response.
module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter bit RST_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             alu_c
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_ctrl;
  logic             owner;
  logic             prio;
  logic             grant;
  logic             accept;
  logic             rsp_done;

  // Lone requester wins; on contention the port holding priority wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid)
      grant = prio;
  end

  // Readies are masked during reset so every output reads zero while rst is high.
  assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = !rst && (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_ctrl = op_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      owner      <= 1'b0;
      prio       <= RST_PRIO;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= grant ? req1_a    : req0_a;
            op_b    <= grant ? req1_b    : req0_b;
            op_ctrl <= grant ? req1_ctrl : req0_ctrl;
            owner   <= grant;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_n, alu_z, alu_v, alu_c};
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          // Priority only rotates once the owner has taken its result.
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            prio       <= !owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for alu_arbiter: directed vectors, contention, backpressure,
// reset corner cases and a randomized run against a transaction-level model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_z, alu_n, alu_v, alu_c;

  logic [1:0]  rdy;
  logic [1:0]  rv;

  int passed = 0;
  int total  = 0;

  alu_arbiter #(.WIDTH(32), .RST_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result),
    .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c)
  );

  assign rdy = {req1_ready, req0_ready};
  assign rv  = {rsp1_valid, rsp0_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {result, N, Z, V, C}; V/C only meaningful for ADD/SUB.
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] ctrl);
    logic [31:0] bb, r;
    logic [32:0] sum;
    logic        ovf, v, c;
    bb  = ctrl[0] ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {32'd0, ctrl[0]};
    ovf = (a[31] == bb[31]) && (sum[31] != a[31]);
    v   = 1'b0;
    c   = 1'b0;
    case (ctrl)
      3'b000, 3'b001: begin r = sum[31:0]; v = ovf; c = sum[32]; end
      3'b010:         r = a & b;
      3'b011:         r = a | b;
      3'b101:         r = {31'd0, sum[31] ^ ovf};
      default:        r = 32'd0;
    endcase
    return {r, r[31], (r == 32'd0), v, c};
  endfunction

  always_comb {alu_result, alu_n, alu_z, alu_v, alu_c} = alu_ref(alu_a, alu_b, alu_ctrl);

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input logic port, input logic v, input logic [31:0] a,
                                input logic [31:0] b, input logic [2:0] ctrl);
    if (port) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = ctrl;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = ctrl;
    end
  endtask

  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[9];

  // Single isolated transaction on one port with fixed latency expectations.
  task automatic run_vector(input int idx, input vec_t v);
    logic [1:0] mine;
    string tag;
    mine = v.port ? 2'b10 : 2'b01;
    tag  = $sformatf("vec%0d", idx);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    apply_stimulus(!v.port, 1'b0, 32'd0, 32'd0, 3'd0);
    apply_stimulus(v.port, 1'b1, v.a, v.b, v.ctrl);
    #1;
    check_output({tag, " ready"}, 64'(rdy), 64'(mine));
    next_cycle();
    apply_stimulus(v.port, 1'b0, v.a, v.b, v.ctrl);
    #1;
    check_output({tag, " exec rsp_valid"}, 64'(rv), 64'(0));
    check_output({tag, " exec alu ops"}, 64'({alu_a, alu_b[28:0], alu_ctrl}),
                 64'({v.a, v.b[28:0], v.ctrl}));
    next_cycle();
    check_output({tag, " rsp_valid"}, 64'(rv), 64'(mine));
    check_output({tag, " result"}, 64'(rsp_result), 64'(v.res));
    check_output({tag, " flags"}, 64'(rsp_flags), 64'(v.flags));
    if (v.port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    next_cycle();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check_output({tag, " rsp_valid after"}, 64'(rv), 64'(0));
  endtask

  logic [35:0] e;
  logic [31:0] held_res;
  logic [3:0]  held_flags;
  int          idx0, idx1;
  logic        own;

  // Randomized-run model state: at most one transaction in flight.
  logic        m_busy, m_owner, m_prio;
  int          m_age;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_ctrl;
  logic [1:0]  e_rdy, e_rv;
  logic        acc0, acc1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 32'd5,        32'd7,        3'b000, 32'd12,       4'b0000};
    vecs[1] = '{1'b1, 32'h1234,     32'h1234,     3'b001, 32'd0,        4'b0101};
    vecs[2] = '{1'b1, 32'h7FFFFFFF, 32'd1,        3'b000, 32'h80000000, 4'b1010};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 32'd0,        4'b0100};
    vecs[4] = '{1'b0, 32'd3,        32'd9,        3'b101, 32'd1,        4'b0000};
    vecs[5] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 3'b010, 32'hF000F000, 4'b1000};
    vecs[6] = '{1'b0, 32'h0F0F0000, 32'h000000F0, 3'b011, 32'h0F0F00F0, 4'b0000};
    vecs[7] = '{1'b1, 32'd0,        32'd1,        3'b001, 32'hFFFFFFFF, 4'b1000};
    vecs[8] = '{1'b0, 32'h80000000, 32'd1,        3'b101, 32'd1,        4'b0000};

    rst = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    idx0 = 0; idx1 = 0;
    apply_stimulus(1'b0, 1'b1, 32'd10, 32'd0, 3'b000);
    apply_stimulus(1'b1, 1'b1, 32'd50, 32'd1, 3'b001);
    #12;
    check_output("reset ready", 64'(rdy), 64'(0));
    check_output("reset rsp_valid", 64'(rv), 64'(0));
    check_output("reset rsp regs", 64'({rsp_result, rsp_flags}), 64'(0));
    check_output("reset alu ops", 64'({alu_a, alu_ctrl}), 64'(0));
    check_output("reset alu_b", 64'(alu_b), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Contention from reset: strict alternation 0,1,0,1.
    for (int n = 0; n < 4; n++) begin
      own = n[0];
      apply_stimulus(1'b0, 1'b1, 32'(10 + idx0), 32'(idx0), 3'b000);
      apply_stimulus(1'b1, 1'b1, 32'd50, 32'(idx1 + 1), 3'b001);
      #1;
      check_output($sformatf("contend%0d grant", n), 64'(rdy), 64'(own ? 2'b10 : 2'b01));
      e = own ? alu_ref(32'd50, 32'(idx1 + 1), 3'b001)
              : alu_ref(32'(10 + idx0), 32'(idx0), 3'b000);
      next_cycle();
      if (own) idx1++; else idx0++;
      apply_stimulus(1'b0, 1'b1, 32'(10 + idx0), 32'(idx0), 3'b000);
      apply_stimulus(1'b1, 1'b1, 32'd50, 32'(idx1 + 1), 3'b001);
      #1;
      check_output($sformatf("contend%0d exec", n), 64'({rdy, rv}), 64'(0));
      next_cycle();
      check_output($sformatf("contend%0d resp", n), 64'({rdy, rv}),
                   64'({2'b00, own ? 2'b10 : 2'b01}));
      check_output($sformatf("contend%0d result", n), 64'({rsp_result, rsp_flags}), 64'(e));
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    next_cycle();

    for (int i = 0; i < 9; i++) run_vector(i, vecs[i]);

    // Backpressure: port 0 response stalled while port 1 waits.
    do_reset();
    apply_stimulus(1'b0, 1'b1, 32'h00FF, 32'hFF00, 3'b011);
    apply_stimulus(1'b1, 1'b1, 32'd100, 32'd23, 3'b000);
    #1;
    check_output("bp grant", 64'(rdy), 64'(2'b01));
    next_cycle();
    req0_valid = 1'b0;
    #1;
    check_output("bp exec ready", 64'(rdy), 64'(0));
    next_cycle();
    held_res   = rsp_result;
    held_flags = rsp_flags;
    check_output("bp resp", 64'({rv, rsp_result, rsp_flags}), 64'({2'b01, 32'h0000FFFF, 4'b0000}));
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      check_output($sformatf("bp hold%0d", k), 64'({rdy, rv, rsp_result, rsp_flags}),
                   64'({2'b00, 2'b01, held_res, held_flags}));
      check_output($sformatf("bp alu%0d", k), 64'({alu_a, alu_b[15:0], alu_ctrl}),
                   64'({32'h00FF, 16'hFF00, 3'b011}));
    end
    rsp0_ready = 1'b1;
    next_cycle();
    rsp0_ready = 1'b0;
    #1;
    check_output("bp port1 accepted", 64'({rdy, rv}), 64'({2'b10, 2'b00}));
    next_cycle();
    req1_valid = 1'b0;
    #1;
    check_output("bp port1 exec", 64'(rv), 64'(0));
    next_cycle();
    check_output("bp port1 resp", 64'({rv, rsp_result, rsp_flags}), 64'({2'b10, 32'd123, 4'b0000}));
    rsp1_ready = 1'b1;
    next_cycle();
    rsp1_ready = 1'b0;
    #1;
    check_output("bp port1 done", 64'(rv), 64'(0));

    // Reset asserted during the EXEC cycle of an SLT.
    apply_stimulus(1'b0, 1'b1, 32'd3, 32'd9, 3'b101);
    #1;
    check_output("rstexec grant", 64'(rdy), 64'(2'b01));
    next_cycle();
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_output("rstexec ctl outs", 64'({rdy, rv, rsp_flags, alu_ctrl}), 64'(0));
    check_output("rstexec result", 64'(rsp_result), 64'(0));
    check_output("rstexec alu ab", 64'({alu_a, alu_b}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("rstexec no rsp%0d", k), 64'(rv), 64'(0));
      next_cycle();
    end
    run_vector(100, vecs[4]);

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_busy = 1'b0; m_prio = 1'b0; m_owner = 1'b0; m_age = 0;
    m_a = '0; m_b = '0; m_ctrl = '0;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (acc0 || !req0_valid) begin
        if ($urandom_range(0, 2) != 0)
          apply_stimulus(1'b0, 1'b1, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom(),
                         $urandom(), 3'($urandom_range(0, 7)));
        else req0_valid = 1'b0;
      end
      if (acc1 || !req1_valid) begin
        if ($urandom_range(0, 2) != 0)
          apply_stimulus(1'b1, 1'b1, $urandom(),
                         ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom(),
                         3'($urandom_range(0, 7)));
        else req1_valid = 1'b0;
      end
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      #1;
      e_rdy = 2'b00;
      e_rv  = 2'b00;
      if (!m_busy) begin
        if (req0_valid && req1_valid) e_rdy = m_prio ? 2'b10 : 2'b01;
        else e_rdy = {req1_valid, req0_valid};
      end else if (m_age >= 2) begin
        e_rv = m_owner ? 2'b10 : 2'b01;
      end
      check_output($sformatf("rand%0d ready", cyc), 64'(rdy), 64'(e_rdy));
      check_output($sformatf("rand%0d rsp_valid", cyc), 64'(rv), 64'(e_rv));
      if (m_busy)
        check_output($sformatf("rand%0d alu ops", cyc), 64'({alu_a, alu_b[28:0], alu_ctrl}),
                     64'({m_a, m_b[28:0], m_ctrl}));
      if (e_rv != 2'b00)
        check_output($sformatf("rand%0d result", cyc), 64'({rsp_result, rsp_flags}),
                     64'(alu_ref(m_a, m_b, m_ctrl)));
      acc0 = e_rdy[0];
      acc1 = e_rdy[1];
      if (e_rdy != 2'b00) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_owner = e_rdy[1];
        m_a     = e_rdy[1] ? req1_a    : req0_a;
        m_b     = e_rdy[1] ? req1_b    : req0_b;
        m_ctrl  = e_rdy[1] ? req1_ctrl : req0_ctrl;
      end else if (m_busy) begin
        if (m_age >= 2 && (m_owner ? rsp1_ready : rsp0_ready)) begin
          m_busy = 1'b0;
          m_prio = !m_owner;
        end else begin
          m_age++;
        end
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
